systolic_array_ctrl: RTL
========================

Name: systolic_array_ctrl

Overview:
Sequencer for a weight-stationary ROWS x COLS array of MAC PEs. Each PE passes its left operand right and adds wt*left to the partial sum from above. Per job, the block loads one weight row per cycle, then streams cfg_len input vectors from the feature buffer. It generates skewed per-row input valids and per-column output valids, then drains the array and signals done. It sits between the layer scheduler (start/done) and the weight/feature buffers plus the PE grid.

Parameters:
ROWS, 8, PE rows (reduction depth); >=2
COLS, 8, PE columns (output channels); >=2
LEN_W, 16, width of the vector-count field

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
start  input  1  job request pulse; sampled in IDLE only
cfg_len  input  LEN_W  number of input vectors N; captured with start
wt_avail  input  1  weight buffer has a row ready
wt_rd_en  output  1  weight row read/write strobe to PE weight registers
wt_row_sel  output  max(1,$clog2(ROWS))  row index written when wt_rd_en=1
dat_avail  input  1  feature buffer has a vector ready
dat_rd_en  output  1  feature vector read strobe (1-cycle read latency)
row_vld  output  ROWS  skewed valid of left operand entering column 0 per row
col_vld  output  COLS  valid of result at bottom of each column
busy  output  1  high in every state except IDLE
done  output  1  1-cycle pulse at job end

Behaviour:
- Reset: state=IDLE; all outputs 0; counters and skew shift registers cleared. Reset asserted mid-job aborts immediately; no done is issued.
- FSM states: IDLE, WLOAD, STREAM, DRAIN, DONE.
- IDLE + start with cfg_len!=0: latch N, go to WLOAD next cycle.
- IDLE + start with cfg_len==0: go to DONE. No reads occur, so busy=1 for 1 cycle and done pulses the following cycle.
- start outside IDLE is ignored.
- WLOAD: wt_rd_en = wt_avail (combinational). wt_row_sel = row counter, starting at 0 and incrementing on each wt_rd_en. After the ROWS-th read, go to STREAM. wt_avail low inserts idle cycles with no counter change.
- STREAM: dat_rd_en = dat_avail. A vector counter increments per read. On the N-th read, go to DRAIN. Bubbles (dat_avail=0) are legal and propagate as valid=0.
- Skew: a read in cycle k gives row_vld[r]=1 in cycle k+1+r and col_vld[c]=1 in cycle k+1+ROWS+c. Implement as one shift register of depth ROWS+COLS fed by dat_rd_en.
- DRAIN: wait until the whole skew shift register is 0, i.e. col_vld[COLS-1] has emitted its last pulse. Then go to DONE.
- DONE: done=1 for exactly 1 cycle, then IDLE. A start in the same cycle as done is ignored. start is accepted from the next cycle onward.
- There is no output backpressure: the downstream block must capture every col_vld beat.
- Counter widths: the vector counter is LEN_W bits; N=2^LEN_W-1 completes without wrap.
- busy=1 from the cycle after start is accepted through the DONE cycle inclusive.

Test Plan:
1. ROWS=COLS=4, wt_avail/dat_avail tied 1, start with N=3 at cycle 0 -> wt_rd_en cycles 1-4 with sel 0,1,2,3. dat_rd_en cycles 5-7. row_vld[3] cycles 9-11. col_vld[0] cycles 10-12, col_vld[3] cycles 13-15. done at cycle 16, busy cycles 1-16.
2. Same config, dat_avail low in cycle 6 only -> dat_rd_en at cycles 5,7,8. col_vld[0] at 10,12,13 (gap at 11). done at cycle 17.
3. wt_avail low in cycles 2-3 -> wt_row_sel 1 is written in cycle 4, and STREAM starts in cycle 7.
4. start with cfg_len=0 -> busy for 1 cycle, done the next cycle; wt_rd_en, dat_rd_en, row_vld and col_vld never assert.
5. rst_n asserted during DRAIN -> all outputs 0 asynchronously and no done; a new start after release runs a full job correctly.
6. start pulsed during STREAM, and again in the DONE cycle -> both are ignored; a start in the following IDLE cycle is accepted.

Source files
------------

// File: rtl/systolic_array_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : systolic_array_ctrl
// Description : Sequencer for a weight-stationary ROWS x COLS MAC array.
//               Per job: loads ROWS weight rows (one per read), streams
//               cfg_len feature vectors, generates the skewed per-row input
//               valids and per-column output valids, drains, pulses done.
// Ports       : clk, rst_n      - clock, asynchronous active-low reset
//               start, cfg_len  - job request (IDLE only) and vector count
//               wt_avail        - weight row ready   -> wt_rd_en, wt_row_sel
//               dat_avail       - feature vector ready -> dat_rd_en
//               row_vld         - skewed left-operand valid per PE row
//               col_vld         - result valid at the bottom of each column
//               busy, done      - job in progress / 1-cycle end-of-job pulse
// Revision    : 1.0 - initial release
// ============================================================================
module systolic_array_ctrl #(
   parameter int ROWS  = 8,
   parameter int COLS  = 8,
   parameter int LEN_W = 16,
   localparam int SEL_W = (ROWS > 1) ? $clog2(ROWS) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [LEN_W-1:0] cfg_len,
   input  logic             wt_avail,
   output logic             wt_rd_en,
   output logic [SEL_W-1:0] wt_row_sel,
   input  logic             dat_avail,
   output logic             dat_rd_en,
   output logic [ROWS-1:0]  row_vld,
   output logic [COLS-1:0]  col_vld,
   output logic             busy,
   output logic             done
);

   localparam int               DEPTH      = ROWS + COLS;
   localparam logic [SEL_W-1:0] C_LAST_ROW = SEL_W'(ROWS - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_WLOAD  = 3'd1,
      S_STREAM = 3'd2,
      S_DRAIN  = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [LEN_W-1:0]   r_len;
   logic [LEN_W-1:0]   r_vec_cnt;
   logic [SEL_W-1:0]   r_row_cnt;
   // Bit i is high i+1 cycles after a feature read: the low ROWS bits are the
   // row skew, the upper COLS bits the column output skew.
   logic [DEPTH-1:0]   r_skew;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      wt_rd_en    = 1'b0;
      dat_rd_en   = 1'b0;
      busy        = (r_state != S_IDLE);
      done        = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_state_nxt = (cfg_len != '0) ? S_WLOAD : S_DONE;
            end
         end
         S_WLOAD: begin
            wt_rd_en = wt_avail;
            if (wt_avail && (r_row_cnt == C_LAST_ROW)) begin
               w_state_nxt = S_STREAM;
            end
         end
         S_STREAM: begin
            dat_rd_en = dat_avail;
            if (dat_avail && (r_vec_cnt == (r_len - LEN_W'(1)))) begin
               w_state_nxt = S_DRAIN;
            end
         end
         S_DRAIN: begin
            // Leave once only the top bit can still be set: that last
            // col_vld beat is emitted this cycle, so done follows directly.
            if (r_skew[DEPTH-2:0] == '0) begin
               w_state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            done        = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_len     <= '0;
         r_vec_cnt <= '0;
         r_row_cnt <= '0;
         r_skew    <= '0;
      end else begin
         r_skew <= {r_skew[DEPTH-2:0], dat_rd_en};
         if ((r_state == S_IDLE) && start) begin
            r_len     <= cfg_len;
            r_vec_cnt <= '0;
            r_row_cnt <= '0;
         end
         // Row counter returns to 0 after the last row so wt_row_sel reads
         // 0 outside the weight-load phase for any ROWS.
         if (wt_rd_en) begin
            r_row_cnt <= (r_row_cnt == C_LAST_ROW) ? '0 : r_row_cnt + SEL_W'(1);
         end
         if (dat_rd_en) begin
            r_vec_cnt <= r_vec_cnt + LEN_W'(1);
         end
      end
   end

   assign wt_row_sel = r_row_cnt;
   assign row_vld    = r_skew[ROWS-1:0];
   assign col_vld    = r_skew[DEPTH-1:ROWS];

endmodule
`default_nettype wire
